// File: rtl/adc_pkg.sv
// Shared definitions for the ADC capture sequencer: FSM state encoding,
// default sample width and a constant-foldable ceil(log2) helper.
// Combinational constants only; no latency, no flow control.
package adc_pkg;

    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // ceil(log2(value)), usable in parameter and port-width expressions
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_sync_fifo.sv
// Capture FIFO: synchronous, registered wrap-bit pointers, no bypass path.
// Latency: an entry pushed at edge k is visible on o_dat from cycle k+1.
// Backpressure: push refused when full unless a pop happens in the same cycle.
// Ports: i_push/i_dat write side; i_pop read side; o_dat head (0 when empty);
//        o_full/o_empty status; o_level occupancy (updates with push/pop).
module adc_sync_fifo
    import adc_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 8,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_dat,
    input  logic          i_pop,
    output logic [DW-1:0] o_dat,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_do_push;
    logic          w_do_pop;

    // Same index with opposite wrap bits means the writer lapped the reader
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);

    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the slot this same edge, so a full FIFO may still accept
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the head is masked while empty
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
    end

    assign o_dat   = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/adc_sample_ctrl.sv
// Capture sequencer after the decimating ADC chain: settle discard, burst or
// continuous capture into a FIFO, valid/ready delivery downstream.
// Latency: captured sample appears on m_data one cycle after its chain_vld_in.
// Backpressure: chain cannot be stalled; samples hitting a full FIFO are
//               dropped, counted toward the burst, and flagged in sticky ovf.
// Ports: cfg_* control, chain_* chain side, m_* output stream, status outputs.
module adc_sample_ctrl
    import adc_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16,
    parameter int SET_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_start,
    input  logic                        cfg_stop,
    input  logic [CNT_W-1:0]            cfg_burst_len,
    input  logic [SET_W-1:0]            cfg_settle_len,
    input  logic                        chain_vld_in,
    input  logic [DW-1:0]               chain_dat_in,
    output logic                        chain_en,
    output logic                        m_valid,
    output logic [DW-1:0]               m_data,
    input  logic                        m_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        ovf,
    output logic [clog2(FIFO_DEPTH):0]  fifo_level
);

    state_t            r_state;
    logic [SET_W-1:0]  r_settle_len;
    logic [SET_W-1:0]  r_settle_cnt;
    logic [CNT_W-1:0]  r_burst_len;
    logic [CNT_W-1:0]  r_cap_cnt;
    logic              r_done;
    logic              r_ovf;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_capture;
    logic              w_push;
    logic              w_drop;
    logic [CNT_W-1:0]  w_cap_nxt;

    assign w_pop     = !w_empty && m_ready;
    assign w_capture = (r_state == ST_RUN) && chain_vld_in;
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;
    assign w_cap_nxt = r_cap_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_settle_len <= '0;
            r_settle_cnt <= '0;
            r_burst_len  <= '0;
            r_cap_cnt    <= '0;
            r_done       <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Stop is meaningless here, so start always wins in IDLE
                    if (cfg_start) begin
                        r_settle_len <= cfg_settle_len;
                        r_burst_len  <= cfg_burst_len;
                        r_settle_cnt <= '0;
                        r_cap_cnt    <= '0;
                        r_ovf        <= 1'b0;
                        r_state      <= (cfg_settle_len != '0) ? ST_SETTLE : ST_RUN;
                    end
                end
                ST_SETTLE: begin
                    if (chain_vld_in) begin
                        r_settle_cnt <= r_settle_cnt + SET_W'(1);
                        if (r_settle_cnt == r_settle_len - SET_W'(1))
                            r_state <= ST_RUN;
                    end
                    if (cfg_stop) r_state <= ST_IDLE;
                end
                ST_RUN: begin
                    if (chain_vld_in) begin
                        r_cap_cnt <= w_cap_nxt;
                        if (w_drop) r_ovf <= 1'b1;
                        // A burst finishing on the stop cycle still reports done
                        if ((r_burst_len != '0) && (w_cap_nxt == r_burst_len)) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                    if (cfg_stop) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    adc_sync_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_dat   (chain_dat_in),
        .i_pop   (w_pop),
        .o_dat   (m_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign m_valid  = !w_empty;
    assign busy     = (r_state != ST_IDLE);
    assign chain_en = busy;
    assign done     = r_done;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl: settle+burst, continuous+stop, overflow,
// full push+pop, random backpressure and mid-run reset.
// Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_adc_sample_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_start;
    logic        cfg_stop;
    logic [15:0] cfg_burst_len;
    logic [7:0]  cfg_settle_len;
    logic        chain_vld_in;
    logic [31:0] chain_dat_in;
    logic        chain_en;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  fifo_level;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_done  = 0;
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    adc_sample_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_start      (cfg_start),
        .cfg_stop       (cfg_stop),
        .cfg_burst_len  (cfg_burst_len),
        .cfg_settle_len (cfg_settle_len),
        .chain_vld_in   (chain_vld_in),
        .chain_dat_in   (chain_dat_in),
        .chain_en       (chain_en),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .busy           (busy),
        .done           (done),
        .ovf            (ovf),
        .fifo_level     (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cap(input logic [7:0] settle, input logic [15:0] burst);
        cfg_settle_len = settle;
        cfg_burst_len  = burst;
        cfg_start      = 1'b1;
        tick();
        cfg_start      = 1'b0;
    endtask

    task automatic stop_cap();
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        m_ready = 1'b1;
        while (m_valid && k < 100) begin
            tick();
            k++;
        end
        chk(tag, 32'(m_valid), 0);
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_item%0d", tag, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    // Output monitor: records handshakes, counts done pulses, checks hold-under-stall
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 1);
                chk("hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) got.push_back(m_data);
            if (done) n_done++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        rst            = 1'b1;
        cfg_start      = 1'b1;
        cfg_stop       = 1'b0;
        cfg_burst_len  = '0;
        cfg_settle_len = '0;
        chain_vld_in   = 1'b0;
        chain_dat_in   = '0;
        m_ready        = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_chain_en", 32'(chain_en), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_level", 32'(fifo_level), 0);
        rst       = 1'b0;
        cfg_start = 1'b0;
        tick();
        chk("post_rst_idle", 32'(busy), 0);

        // Settle 3 then burst 4: samples 1..3 discarded, 4..7 captured
        start_cap(8'd3, 16'd4);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_chain_en", 32'(chain_en), 1);
        for (int i = 1; i <= 10; i++) begin
            chain_vld_in = 1'b1;
            chain_dat_in = 32'(i);
            tick();
            chain_vld_in = 1'b0;
            if (i == 6) chk("t1_busy_mid", 32'(busy), 1);
            if (i == 7) begin
                chk("t1_done", 32'(done), 1);
                chk("t1_busy_fall", 32'(busy), 0);
                chk("t1_chain_en_fall", 32'(chain_en), 0);
            end
            repeat (3) tick();
        end
        for (int i = 4; i <= 7; i++) exp_q.push_back(32'(i));
        cmp_stream("t1_stream");
        chk("t1_done_count", 32'(n_done), 1);

        // Continuous, no settle, 20 samples; last 6 left queued at stop
        start_cap(8'd0, 16'd0);
        for (int i = 0; i < 20; i++) begin
            if (i == 15) m_ready = 1'b0;
            chain_vld_in = 1'b1;
            chain_dat_in = 32'(100 + i);
            exp_q.push_back(32'(100 + i));
            tick();
        end
        chain_vld_in = 1'b0;
        chk("t2_busy_run", 32'(busy), 1);
        stop_cap();
        chk("t2_busy_stop", 32'(busy), 0);
        chk("t2_chain_en_stop", 32'(chain_en), 0);
        chk("t2_level_kept", 32'(fifo_level), 6);
        drain("t2_drain");
        cmp_stream("t2_stream");
        chk("t2_no_done", 32'(n_done), 1);

        // Overflow: burst 12 against a stalled depth-8 FIFO
        m_ready = 1'b0;
        start_cap(8'd0, 16'd12);
        for (int i = 0; i < 12; i++) begin
            chain_vld_in = 1'b1;
            chain_dat_in = 32'(200 + i);
            tick();
            chain_vld_in = 1'b0;
            if (i == 11) begin
                chk("t3_done", 32'(done), 1);
                chk("t3_busy", 32'(busy), 0);
                chk("t3_level", 32'(fifo_level), 8);
                chk("t3_ovf", 32'(ovf), 1);
            end
            tick();
        end
        chk("t3_ovf_sticky", 32'(ovf), 1);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(200 + i));
        drain("t3_drain");
        cmp_stream("t3_stream");
        chk("t3_done_count", 32'(n_done), 2);

        // Full FIFO with simultaneous push and pop
        m_ready = 1'b0;
        start_cap(8'd0, 16'd0);
        chk("t4_ovf_cleared", 32'(ovf), 0);
        for (int i = 0; i < 8; i++) begin
            chain_vld_in = 1'b1;
            chain_dat_in = 32'(300 + i);
            exp_q.push_back(32'(300 + i));
            tick();
        end
        chk("t4_level_full", 32'(fifo_level), 8);
        chain_dat_in = 32'(308);
        exp_q.push_back(32'(308));
        m_ready = 1'b1;
        tick();
        chain_vld_in = 1'b0;
        m_ready      = 1'b0;
        chk("t4_level_pp", 32'(fifo_level), 8);
        chk("t4_ovf_pp", 32'(ovf), 0);
        chk("t4_head", m_data, 32'(301));
        stop_cap();
        drain("t4_drain");
        cmp_stream("t4_stream");

        // Random backpressure, 50 samples one every 3 cycles
        start_cap(8'd0, 16'd0);
        for (int i = 0; i < 50; i++) begin
            chain_vld_in = 1'b1;
            chain_dat_in = 32'(500 + i);
            exp_q.push_back(32'(500 + i));
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
            chain_vld_in = 1'b0;
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        stop_cap();
        drain("t5_drain");
        cmp_stream("t5_stream");
        chk("t5_no_ovf", 32'(ovf), 0);

        // Reset during RUN with 5 entries queued; start held through reset
        m_ready = 1'b0;
        start_cap(8'd0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            chain_vld_in = 1'b1;
            chain_dat_in = 32'(600 + i);
            tick();
        end
        chain_vld_in = 1'b0;
        chk("t6_level_pre", 32'(fifo_level), 5);
        rst       = 1'b1;
        cfg_start = 1'b1;
        tick();
        chk("t6_m_valid", 32'(m_valid), 0);
        chk("t6_m_data", m_data, 0);
        chk("t6_level", 32'(fifo_level), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_chain_en", 32'(chain_en), 0);
        tick();
        chk("t6_busy_held", 32'(busy), 0);
        rst       = 1'b0;
        cfg_start = 1'b0;
        tick();
        chk("t6_busy_after", 32'(busy), 0);
        chk("t6_valid_after", 32'(m_valid), 0);
        chk("t6_nothing_out", got.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
